mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access.

---
 rtl/mem_port_arbiter_pkg.sv | 28 ++
 rtl/mem_arb_timeout.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter: FSM state
//   encodings, the grant decision type, the word-size memControl code used for
//   instruction fetches, and default tuning constants.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        F_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DATA  = 2'd1,
        GNT_FETCH = 2'd2
    } grant_t;

    // Fetches always read a full 32-bit instruction word.
    localparam logic [2:0] MEMCTL_WORD = 3'b010;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/mem_arb_timeout.sv
// ----------------------------------------------------------------------------
// mem_arb_timeout
//   Watchdog counter for a memory master waiting on an acknowledge. Counts
//   enabled cycles and flags the last permitted one, so the owner can abort
//   the access on the same edge it would otherwise keep waiting.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      synchronous, active-high reset
//   clr_i      zero the count (takes priority over en_i)
//   en_i       count this cycle (master is waiting)
//   expired_o  high during the TIMEOUT-th enabled cycle
// ----------------------------------------------------------------------------
module mem_arb_timeout
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of waiting cycles already elapsed, so the
    // TIMEOUT-th waiting cycle sees TIMEOUT-1.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF stage) and
//   data access (MEM stage). Data wins collisions, except that after
//   STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch is
//   forced through. Each access runs IDLE -> BUSY -> RESP; the RESP cycle
//   carries the one-cycle valid pulse. An access with no acknowledge within
//   TIMEOUT busy cycles is aborted and completes with err and zero read data.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   if_req_i / if_addr_i     fetch request (held until if_valid_o) and address
//   if_rdata_o / if_valid_o  fetched instruction (m_rdata_i[31:0]), done pulse
//   d_req_i, d_we_i          data request (held until d_valid_o), store enable
//   d_addr_i, d_wdata_i      data address and store data
//   d_ctrl_i                 size/sign code, forwarded to m_ctrl_o
//   d_rdata_o / d_valid_o    load data, done pulse
//   err_o                    pulse alongside a valid that ended by timeout
//   stall_o                  request outstanding and not completing this cycle
//   m_req_o .. m_ctrl_o      registered memory request, held through BUSY
//   m_ack_i / m_rdata_i      memory done and read data (same cycle)
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_req_i,
    input  logic [WIDTH-1:0] if_addr_i,
    output logic [31:0]      if_rdata_o,
    output logic             if_valid_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [WIDTH-1:0] d_addr_i,
    input  logic [WIDTH-1:0] d_wdata_i,
    input  logic [2:0]       d_ctrl_i,
    output logic [WIDTH-1:0] d_rdata_o,
    output logic             d_valid_o,
    output logic             err_o,
    output logic             stall_o,
    output logic             m_req_o,
    output logic             m_we_o,
    output logic [WIDTH-1:0] m_addr_o,
    output logic [WIDTH-1:0] m_wdata_o,
    output logic [2:0]       m_ctrl_o,
    input  logic             m_ack_i,
    input  logic [WIDTH-1:0] m_rdata_i
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t           state_q;
    grant_t           grant_d;
    logic [SW-1:0]    starve_q;
    logic             busy;
    logic             tmo_expired;

    logic             m_req_q;
    logic             m_we_q;
    logic [WIDTH-1:0] m_addr_q;
    logic [WIDTH-1:0] m_wdata_q;
    logic [2:0]       m_ctrl_q;
    logic [31:0]      if_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;
    logic             if_valid_q;
    logic             d_valid_q;
    logic             err_q;

    assign busy = (state_q == D_BUSY) || (state_q == F_BUSY);

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!busy),
        .en_i      (busy),
        .expired_o (tmo_expired)
    );

    // Arbitration decision; only acted on while the FSM is in IDLE.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_d = GNT_NONE;
        if (d_req_i && (!if_req_i || (starve_q < STARVE_MAX))) begin
            grant_d = GNT_DATA;
        end else if (if_req_i) begin
            grant_d = GNT_FETCH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_ctrl_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Completion flags are pulses: set only on the edge into RESP.
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    case (grant_d)
                        GNT_DATA: begin
                            state_q   <= D_BUSY;
                            m_req_q   <= 1'b1;
                            m_we_q    <= d_we_i;
                            m_addr_q  <= d_addr_i;
                            m_wdata_q <= d_wdata_i;
                            m_ctrl_q  <= d_ctrl_i;
                            // Only a grant that bypassed a waiting fetch counts
                            // toward starvation.
                            starve_q  <= if_req_i ? starve_q + 1'b1 : '0;
                        end
                        GNT_FETCH: begin
                            state_q   <= F_BUSY;
                            m_req_q   <= 1'b1;
                            m_we_q    <= 1'b0;
                            m_addr_q  <= if_addr_i;
                            m_wdata_q <= '0;
                            m_ctrl_q  <= MEMCTL_WORD;
                            starve_q  <= '0;
                        end
                        default: begin
                            starve_q  <= '0;
                        end
                    endcase
                end

                D_BUSY, F_BUSY: begin
                    // An acknowledge in the final allowed cycle still wins.
                    if (m_ack_i || tmo_expired) begin
                        state_q <= RESP;
                        m_req_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        err_q   <= !m_ack_i;
                        if (state_q == D_BUSY) begin
                            d_valid_q <= 1'b1;
                            d_rdata_q <= m_ack_i ? m_rdata_i : '0;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= m_ack_i ? m_rdata_i[31:0] : '0;
                        end
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_req_o    = m_req_q;
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign m_ctrl_o   = m_ctrl_q;
    assign if_rdata_o = if_rdata_q;
    assign if_valid_o = if_valid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_valid_o  = d_valid_q;
    assign err_o      = err_q;
    assign stall_o    = (if_req_i | d_req_i) & ~(if_valid_q | d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Inputs are driven 1 time unit
//   after each rising edge and outputs are sampled 1 unit later, so the
//   "cycle" seen here is the interval between two rising edges.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int W = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          if_req_i;
    logic [W-1:0]  if_addr_i;
    logic [31:0]   if_rdata_o;
    logic          if_valid_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [W-1:0]  d_addr_i;
    logic [W-1:0]  d_wdata_i;
    logic [2:0]    d_ctrl_i;
    logic [W-1:0]  d_rdata_o;
    logic          d_valid_o;
    logic          err_o;
    logic          stall_o;
    logic          m_req_o;
    logic          m_we_o;
    logic [W-1:0]  m_addr_o;
    logic [W-1:0]  m_wdata_o;
    logic [2:0]    m_ctrl_o;
    logic          m_ack_i;
    logic [W-1:0]  m_rdata_i;

    mem_port_arbiter #(
        .WIDTH        (W),
        .STARVE_LIMIT (4),
        .TIMEOUT      (255)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_valid_o (if_valid_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ctrl_i   (d_ctrl_i),
        .d_rdata_o  (d_rdata_o),
        .d_valid_o  (d_valid_o),
        .err_o      (err_o),
        .stall_o    (stall_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_ctrl_o   (m_ctrl_o),
        .m_ack_i    (m_ack_i),
        .m_rdata_i  (m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        d_ctrl_i  = 3'b000;
        m_ack_i   = 1'b0;
        m_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // One isolated access from a freshly reset arbiter. Cycle 1 is the cycle
    // the request(s) are first presented; the memory acks in BUSY cycle
    // lat+1, i.e. cycle 2+lat, and the valid appears in cycle 3+lat.
    typedef struct {
        logic        d_req;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [2:0]  d_ctrl;
        logic        if_req;
        logic [63:0] if_addr;
        int          lat;
        logic [63:0] rdata;
        logic        exp_data;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [2:0]  exp_ctrl;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];
    vec_t v;

    // Random-test state
    int          owner;          // 0 none, 1 data, 2 fetch
    int          gnt_c, ack_c, resp_c, streak;
    bit          d_pend, f_pend, d_drop, f_drop, in_window, exp_dv, exp_iv;
    logic        rd_we;
    logic [63:0] rd_addr, rd_wdata, rf_addr, mem_data;
    logic [2:0]  rd_ctrl;
    logic        t_we;
    logic [63:0] t_addr, t_wdata;
    logic [2:0]  t_ctrl;

    int          gcount, busy_cnt;
    bit          prev_req, done;

    initial begin
        // T1 is row 0; rows 2 and 4 are collisions where data must win.
        vecs[0] = '{1'b0, 1'b0, 64'h0, 64'h0, 3'b000, 1'b1, 64'h40, 1, 64'h0000_0000_00A0_0093,
                    1'b0, 1'b0, 64'h40, 64'h0, 3'b010, 64'h0000_0000_00A0_0093};
        vecs[1] = '{1'b1, 1'b0, 64'h2000, 64'h0, 3'b011, 1'b0, 64'h0, 0, 64'h1122_3344_5566_7788,
                    1'b1, 1'b0, 64'h2000, 64'h0, 3'b011, 64'h1122_3344_5566_7788};
        vecs[2] = '{1'b1, 1'b1, 64'h100, 64'hDEAD, 3'b011, 1'b1, 64'h80, 2, 64'hCAFE,
                    1'b1, 1'b1, 64'h100, 64'hDEAD, 3'b011, 64'hCAFE};
        vecs[3] = '{1'b0, 1'b0, 64'h0, 64'h0, 3'b000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_EEEE_8765_4321,
                    1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 3'b010, 64'h0000_0000_8765_4321};
        vecs[4] = '{1'b1, 1'b0, 64'h8000_0000_0000_0008, 64'h0, 3'b100, 1'b1, 64'h44, 3, 64'h0BAD_F00D_1234_5678,
                    1'b1, 1'b0, 64'h8000_0000_0000_0008, 64'h0, 3'b100, 64'h0BAD_F00D_1234_5678};

        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("rst_m_req",    m_req_o,    0);
        check("rst_m_we",     m_we_o,     0);
        check("rst_m_addr",   m_addr_o,   0);
        check("rst_if_valid", if_valid_o, 0);
        check("rst_d_valid",  d_valid_o,  0);
        check("rst_err",      err_o,      0);
        check("rst_stall",    stall_o,    0);
        check("rst_d_rdata",  d_rdata_o,  0);
        tick();

        // ---------------- table-driven single accesses ----------------
        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            do_reset();
            for (int c = 1; c <= 3 + v.lat; c++) begin
                d_req_i   = v.d_req;
                d_we_i    = v.d_we;
                d_addr_i  = v.d_addr;
                d_wdata_i = v.d_wdata;
                d_ctrl_i  = v.d_ctrl;
                if_req_i  = v.if_req;
                if_addr_i = v.if_addr;
                if (c == 3 + v.lat) begin
                    if (v.exp_data) d_req_i = 1'b0;
                    else            if_req_i = 1'b0;
                end
                m_ack_i   = (c == 2 + v.lat);
                m_rdata_i = m_ack_i ? v.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
                #1;
                if (c == 2) begin
                    check($sformatf("vec%0d_m_req",  k), m_req_o,  1);
                    check($sformatf("vec%0d_m_we",   k), m_we_o,   v.exp_we);
                    check($sformatf("vec%0d_m_addr", k), m_addr_o, v.exp_addr);
                    check($sformatf("vec%0d_m_ctrl", k), m_ctrl_o, v.exp_ctrl);
                    if (v.exp_data) check($sformatf("vec%0d_m_wdata", k), m_wdata_o, v.exp_wdata);
                end
                if (c < 3 + v.lat) begin
                    check($sformatf("vec%0d_c%0d_valid", k, c), d_valid_o | if_valid_o, 0);
                    check($sformatf("vec%0d_c%0d_stall", k, c), stall_o, 1);
                end else begin
                    check($sformatf("vec%0d_m_req_drop", k), m_req_o,    0);
                    check($sformatf("vec%0d_d_valid",    k), d_valid_o,  v.exp_data);
                    check($sformatf("vec%0d_if_valid",   k), if_valid_o, !v.exp_data);
                    check($sformatf("vec%0d_err",        k), err_o,      0);
                    check($sformatf("vec%0d_stall_done", k), stall_o,    0);
                    if (v.exp_data) check($sformatf("vec%0d_d_rdata", k), d_rdata_o, v.exp_rdata);
                    else            check($sformatf("vec%0d_if_rdata", k), {32'h0, if_rdata_o}, v.exp_rdata);
                end
                tick();
            end
        end

        // ---------------- T2: collision, then one idle cycle, then fetch ----------------
        do_reset();
        if_req_i = 1'b1; if_addr_i = 64'h40;
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 64'h100; d_wdata_i = 64'hDEAD; d_ctrl_i = 3'b011;
        #1; tick();                                   // cycle 1: both sampled in IDLE
        m_ack_i = 1'b1; m_rdata_i = 64'h0;
        #1;
        check("t2_m_we",    m_we_o,    1);
        check("t2_m_addr",  m_addr_o,  64'h100);
        check("t2_m_wdata", m_wdata_o, 64'hDEAD);
        tick();                                       // cycle 3: RESP
        m_ack_i = 1'b0; d_req_i = 1'b0;
        #1;
        check("t2_d_valid",  d_valid_o,  1);
        check("t2_if_valid", if_valid_o, 0);
        tick();                                       // cycle 4: IDLE, fetch sampled
        #1;
        check("t2_idle_m_req", m_req_o, 0);
        check("t2_idle_stall", stall_o, 1);
        tick();                                       // cycle 5: fetch BUSY
        m_ack_i = 1'b1; m_rdata_i = 64'h0000_0013;
        #1;
        check("t2_f_m_req",  m_req_o,  1);
        check("t2_f_m_addr", m_addr_o, 64'h40);
        check("t2_f_m_ctrl", m_ctrl_o, 3'b010);
        check("t2_f_m_we",   m_we_o,   0);
        tick();                                       // cycle 6: RESP
        m_ack_i = 1'b0; if_req_i = 1'b0;
        #1;
        check("t2_f_valid", if_valid_o, 1);
        check("t2_f_rdata", if_rdata_o, 32'h13);
        tick();

        // ---------------- T3: starvation limit ----------------
        do_reset();
        if_addr_i = 64'h40; if_req_i = 1'b1;
        d_addr_i = 64'h300; d_we_i = 1'b0; d_ctrl_i = 3'b011; d_req_i = 1'b1;
        gcount = 0; prev_req = 1'b0;
        for (int c = 0; c < 200 && gcount < 10; c++) begin
            if (c > 0) begin
                d_req_i  = !d_valid_o;    // drop in RESP, re-raise next cycle
                if_req_i = !if_valid_o;
                m_ack_i  = m_req_o;       // memory answers in the first BUSY cycle
            end
            #1;
            if (m_req_o && !prev_req) begin
                check($sformatf("t3_grant%0d_addr", gcount), m_addr_o,
                      (gcount % 5 == 4) ? 64'h40 : 64'h300);
                gcount++;
            end
            prev_req = m_req_o;
            tick();
        end
        check("t3_grant_count", gcount, 10);

        // ---------------- T4: timeout ----------------
        do_reset();
        d_addr_i = 64'h500; d_we_i = 1'b0; d_ctrl_i = 3'b011; d_req_i = 1'b1;
        #1; tick();
        m_ack_i = 1'b1; m_rdata_i = 64'h55;
        #1; tick();
        m_ack_i = 1'b0; d_req_i = 1'b0;
        #1;
        check("t4_pre_rdata", d_rdata_o, 64'h55);
        check("t4_pre_err",   err_o,     0);
        tick();
        d_req_i = 1'b1; m_rdata_i = '1;
        busy_cnt = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (m_req_o) busy_cnt++;
            if (d_valid_o) begin
                done = 1'b1;
                check("t4_busy_cycles", busy_cnt,  255);
                check("t4_m_req_low",   m_req_o,   0);
                check("t4_err",         err_o,     1);
                check("t4_d_rdata",     d_rdata_o, 0);
                d_req_i = 1'b0;
            end
            tick();
        end
        check("t4_completed", done, 1);
        #1;
        check("t4_err_pulse", err_o, 0);
        tick();

        // ---------------- T5: reset during fetch BUSY ----------------
        do_reset();
        if_addr_i = 64'h40; if_req_i = 1'b1;
        #1; tick();                                   // cycle 1 sampled in IDLE
        rst_i = 1'b1;
        #1;
        check("t5_busy_m_req", m_req_o, 1);
        tick();
        rst_i = 1'b0; if_req_i = 1'b0; m_ack_i = 1'b1; m_rdata_i = 64'h1234;
        #1;
        check("t5_m_req",    m_req_o,    0);
        check("t5_if_valid", if_valid_o, 0);
        tick();
        m_ack_i = 1'b0;
        d_req_i = 1'b1; d_addr_i = 64'h600; d_we_i = 1'b0; d_ctrl_i = 3'b011;
        #1;
        check("t5_late_valid", if_valid_o | d_valid_o, 0);
        check("t5_late_err",   err_o,      0);
        check("t5_late_m_req", m_req_o,    0);
        check("t5_if_rdata",   if_rdata_o, 0);
        tick();
        m_ack_i = 1'b1; m_rdata_i = 64'h6666;
        #1;
        check("t5_regrant_m_req",  m_req_o,  1);
        check("t5_regrant_m_addr", m_addr_o, 64'h600);
        tick();
        m_ack_i = 1'b0; d_req_i = 1'b0;
        #1;
        check("t5_regrant_valid", d_valid_o, 1);
        check("t5_regrant_rdata", d_rdata_o, 64'h6666);
        tick();

        // ---------------- T6: stray acks in IDLE and RESP ----------------
        do_reset();
        m_ack_i = 1'b1; m_rdata_i = 64'h77;
        #1; tick();
        m_ack_i = 1'b0;
        #1;
        check("t6_idle_valid", if_valid_o | d_valid_o, 0);
        check("t6_idle_err",   err_o,   0);
        check("t6_idle_m_req", m_req_o, 0);
        tick();
        d_req_i = 1'b1; d_addr_i = 64'h700; d_we_i = 1'b0; d_ctrl_i = 3'b011;
        #1; tick();
        m_ack_i = 1'b1; m_rdata_i = 64'h99;
        #1;
        check("t6_m_req", m_req_o, 1);
        tick();
        d_req_i = 1'b0; m_ack_i = 1'b1; m_rdata_i = 64'hAA;
        #1;
        check("t6_d_valid", d_valid_o, 1);
        check("t6_d_rdata", d_rdata_o, 64'h99);
        tick();
        m_ack_i = 1'b0;
        #1;
        check("t6_resp_valid", if_valid_o | d_valid_o, 0);
        check("t6_resp_err",   err_o,     0);
        check("t6_resp_m_req", m_req_o,   0);
        check("t6_resp_rdata", d_rdata_o, 64'h99);
        tick();

        // ---------------- randomized traffic vs timeline model ----------------
        // The model tracks each access as a timeline: granted in cycle gnt_c,
        // memory busy up to the ack in ack_c, valid in resp_c = ack_c+1, and
        // the next arbitration one cycle after that.
        do_reset();
        owner = 0; streak = 0; d_pend = 1'b0; f_pend = 1'b0;
        gnt_c = 0; ack_c = 0; resp_c = 0;
        rd_we = 1'b0; rd_addr = '0; rd_wdata = '0; rd_ctrl = 3'b000; rf_addr = '0;
        t_we = 1'b0; t_addr = '0; t_wdata = '0; t_ctrl = 3'b000; mem_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            d_drop = 1'b0; f_drop = 1'b0;
            if (owner != 0 && cyc == resp_c) begin
                if (owner == 1) begin d_pend = 1'b0; d_drop = 1'b1; end
                else            begin f_pend = 1'b0; f_drop = 1'b1; end
            end
            if (!d_pend && !d_drop && $urandom_range(0, 2) == 0) begin
                d_pend   = 1'b1;
                rd_we    = 1'($urandom_range(0, 1));
                rd_addr  = {$urandom, $urandom};
                rd_wdata = {$urandom, $urandom};
                rd_ctrl  = 3'($urandom_range(0, 7));
            end
            if (!f_pend && !f_drop && $urandom_range(0, 1) == 0) begin
                f_pend  = 1'b1;
                rf_addr = {$urandom, $urandom};
            end

            if (owner == 0) begin
                if (d_pend && (!f_pend || streak < 4)) begin
                    owner = 1;
                    streak = f_pend ? streak + 1 : 0;
                    t_we = rd_we; t_addr = rd_addr; t_wdata = rd_wdata; t_ctrl = rd_ctrl;
                end else if (f_pend) begin
                    owner = 2;
                    streak = 0;
                    t_we = 1'b0; t_addr = rf_addr; t_wdata = '0; t_ctrl = 3'b010;
                end else begin
                    streak = 0;
                end
                if (owner != 0) begin
                    gnt_c    = cyc;
                    ack_c    = cyc + 1 + $urandom_range(0, 4);
                    resp_c   = ack_c + 1;
                    mem_data = {$urandom, $urandom};
                end
            end

            d_req_i   = d_pend;
            d_we_i    = rd_we;
            d_addr_i  = rd_addr;
            d_wdata_i = rd_wdata;
            d_ctrl_i  = rd_ctrl;
            if_req_i  = f_pend;
            if_addr_i = rf_addr;
            in_window = (owner != 0) && (cyc > gnt_c) && (cyc <= ack_c);
            if (owner != 0 && cyc == ack_c) begin
                m_ack_i   = 1'b1;
                m_rdata_i = mem_data;
            end else begin
                m_ack_i   = !in_window && ($urandom_range(0, 7) == 0);
                m_rdata_i = {$urandom, $urandom};
            end
            #1;

            exp_dv = (owner == 1) && (cyc == resp_c);
            exp_iv = (owner == 2) && (cyc == resp_c);
            check("rnd_m_req",    m_req_o,    in_window);
            check("rnd_d_valid",  d_valid_o,  exp_dv);
            check("rnd_if_valid", if_valid_o, exp_iv);
            check("rnd_err",      err_o,      0);
            check("rnd_stall",    stall_o,    (d_pend | f_pend) & !(exp_dv | exp_iv));
            if (owner != 0 && cyc == gnt_c + 1) begin
                check("rnd_m_addr", m_addr_o, t_addr);
                check("rnd_m_we",   m_we_o,   t_we);
                check("rnd_m_ctrl", m_ctrl_o, t_ctrl);
                if (owner == 1) check("rnd_m_wdata", m_wdata_o, t_wdata);
            end
            if (exp_dv) check("rnd_d_rdata",  d_rdata_o, mem_data);
            if (exp_iv) check("rnd_if_rdata", {32'h0, if_rdata_o}, {32'h0, mem_data[31:0]});
            if (owner != 0 && cyc == resp_c) owner = 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
